pipe_stage_ctrl: RTL and testbench

Parametrised pipeline sequencing unit for the MIPS core family. It generates per-stage reset, enable and valid signals for an N-stage in-order pipeline from per-stage stall and flush requests. It also provides a debug halt / multi-step state machine. It sits between the hazard logic and the datapath stage registers, replacing the fixed 5-stage if/id/exe/mem/wb handshake with one generic vector interface.

---
 rtl/pipe_stage_ctrl_if.sv | 27 ++
 rtl/pipe_stage_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_ctrl_if.sv
// Pipeline sequencing bus: hazard/debug requests in, per-stage controls out.
// master = requester side (hazard logic / debugger), slave = pipe_stage_ctrl.
interface pipe_stage_ctrl_if #(
    parameter int STAGES = 5,
    parameter int STEP_W = 8
);
    logic              debug_en;
    logic              debug_step;
    logic [STEP_W-1:0] debug_count;
    logic [STAGES-1:0] stall_req;
    logic [STAGES-1:0] flush_req;
    logic [STAGES-1:0] stage_rst;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic              halted;
    logic              step_busy;

    modport master (
        output debug_en, debug_step, debug_count, stall_req, flush_req,
        input  stage_rst, stage_en, stage_valid, halted, step_busy
    );

    modport slave (
        input  debug_en, debug_step, debug_count, stall_req, flush_req,
        output stage_rst, stage_en, stage_valid, halted, step_busy
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Generic N-stage pipeline sequencer: turns per-stage stall/flush requests
// into stage register clear/enable, tracks which stages hold real
// instructions, and runs a debug halt / step-burst state machine.

// One stage's valid bit: a clear loads a bubble, an enable shifts in the
// upstream valid, otherwise the bit holds.
module psc_valid_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic prev_i,
    output logic vld_o
);
    logic vld_q;

    // Valid bit update, clear wins over enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        vld_q <= 1'b0;
        else if (clr_i)  vld_q <= 1'b0;
        else if (en_i)   vld_q <= prev_i;
    end

    assign vld_o = vld_q;
endmodule

module pipe_stage_ctrl #(
    parameter int STAGES = 5,
    parameter int STEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              step_prev_q;
    logic              halted_q, busy_q;

    logic              run;
    logic              step_edge;
    logic              advancing;
    logic [STAGES-1:0] blk;       // blk[j]: some stage at or above j is stalled
    logic [STAGES-1:0] bubble;    // stage directly above the highest stall
    logic [STAGES-1:0] stg_rst;
    logic [STAGES-1:0] stg_en;
    logic [STAGES-1:0] valid;

    assign run       = (state_q != ST_HALT);
    assign step_edge = bus.debug_step & ~step_prev_q;
    assign advancing = run & ~(|bus.stall_req);

    // State register plus counter, step edge history and registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            step_prev_q <= 1'b0;
            halted_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_prev_q <= bus.debug_step;
            halted_q    <= (state_d == ST_HALT);
            busy_q      <= (state_d == ST_STEP);
        end
    end

    // Next-state: halt on debug, step bursts count only advancing cycles,
    // leaving debug mode returns to RUN from anywhere
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.debug_en) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (step_edge) begin
                    state_d = ST_STEP;
                    // A zero burst length still executes one cycle
                    cnt_d   = (bus.debug_count == '0) ? STEP_W'(1) : bus.debug_count;
                end
            end
            ST_STEP: begin
                if (advancing) begin
                    // Counter stops at 1; the last advancing cycle exits instead
                    if (cnt_q == STEP_W'(1)) state_d = ST_HALT;
                    else                     cnt_d   = cnt_q - STEP_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (!bus.debug_en) state_d = ST_RUN;
    end

    // Output decode: stages above the highest stall advance, the stage just
    // above it takes a bubble, flushes clear; reset forces everything clear
    always_comb begin
        blk    = '0;
        bubble = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            if (j == STAGES - 1) blk[j] = bus.stall_req[j];
            else                 blk[j] = bus.stall_req[j] | blk[j+1];
        end
        for (int j = 1; j < STAGES; j++) begin
            bubble[j] = bus.stall_req[j-1] & ~blk[j];
        end
        stg_en  = {STAGES{run}} & ~blk;
        stg_rst = {STAGES{run}} & (bubble | bus.flush_req);
        if (!rst) begin
            stg_en  = '0;
            stg_rst = '1;
        end
    end

    // Per-stage valid tracking
    for (genvar i = 0; i < STAGES; i++) begin : g_vld
        psc_valid_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (stg_rst[i]),
            .en_i   (stg_en[i]),
            .prev_i ((i == 0) ? 1'b1 : valid[(i == 0) ? 0 : i-1]),
            .vld_o  (valid[i])
        );
    end

    assign bus.stage_en    = stg_en;
    assign bus.stage_rst   = stg_rst;
    assign bus.stage_valid = valid;
    assign bus.halted      = halted_q;
    assign bus.step_busy   = busy_q;
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl, STAGES=5, STEP_W=8.
module tb_pipe_stage_ctrl;
    localparam int STAGES = 5;
    localparam int STEP_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipe_stage_ctrl_if #(.STAGES(STAGES), .STEP_W(STEP_W)) bus ();

    pipe_stage_ctrl #(.STAGES(STAGES), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nb, ne, adv;
        bus.debug_en    = 1'b0;
        bus.debug_step  = 1'b0;
        bus.debug_count = '0;
        bus.stall_req   = '0;
        bus.flush_req   = '0;

        // Reset state
        #2;
        chk("rst_stage_rst", 32'(bus.stage_rst), 32'h1f);
        chk("rst_stage_en", 32'(bus.stage_en), 32'h00);
        chk("rst_valid", 32'(bus.stage_valid), 32'h00);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_busy", 32'(bus.step_busy), 32'h0);

        // Reset release and fill
        tick();
        rst = 1'b1;
        #1;
        chk("run_en", 32'(bus.stage_en), 32'h1f);
        chk("run_rst", 32'(bus.stage_rst), 32'h00);
        for (int i = 0; i < STAGES; i++) begin
            tick();
            chk($sformatf("fill%0d", i), 32'(bus.stage_valid), (32'd1 << (i + 1)) - 32'd1);
        end

        // Load-use stall on stage 1
        bus.stall_req = 5'b00010;
        #1;
        chk("lu_en", 32'(bus.stage_en), 32'h1c);
        chk("lu_rst", 32'(bus.stage_rst), 32'h04);
        tick();
        bus.stall_req = '0;
        chk("lu_valid", 32'(bus.stage_valid), 32'h1b);
        tick();
        chk("lu_valid2", 32'(bus.stage_valid), 32'h17);

        // Branch flush of IF
        bus.flush_req = 5'b00001;
        #1;
        chk("fl_rst", 32'(bus.stage_rst), 32'h01);
        chk("fl_en", 32'(bus.stage_en), 32'h1f);
        tick();
        bus.flush_req = '0;
        chk("fl_valid", 32'(bus.stage_valid), 32'h0e);

        // Stall at k with flush at i<=k: that stage clears and stays disabled
        bus.stall_req = 5'b01000;
        bus.flush_req = 5'b00100;
        #1;
        chk("sf_rst", 32'(bus.stage_rst), 32'h14);
        chk("sf_en", 32'(bus.stage_en), 32'h10);
        bus.stall_req = '0;
        bus.flush_req = '0;

        // Debug halt: still running in the cycle debug_en rises
        bus.debug_en = 1'b1;
        #1;
        chk("dbg_t_en", 32'(bus.stage_en), 32'h1f);
        chk("dbg_t_halted", 32'(bus.halted), 32'h0);
        tick();
        chk("dbg_halted", 32'(bus.halted), 32'h1);
        chk("dbg_en", 32'(bus.stage_en), 32'h00);
        chk("dbg_valid", 32'(bus.stage_valid), 32'h1d);
        bus.flush_req = 5'b11111;
        bus.stall_req = 5'b00001;
        #1;
        chk("hlt_ign_rst", 32'(bus.stage_rst), 32'h00);
        chk("hlt_ign_en", 32'(bus.stage_en), 32'h00);
        bus.flush_req = '0;
        bus.stall_req = '0;
        tick();
        chk("hlt_valid_hold", 32'(bus.stage_valid), 32'h1d);
        chk("hlt_still", 32'(bus.halted), 32'h1);

        // Step burst of 3 with one stall cycle in the middle
        bus.debug_count = 8'd3;
        bus.debug_step  = 1'b1;
        #1;
        chk("st_pre_busy", 32'(bus.step_busy), 32'h0);
        tick();
        chk("st_busy", 32'(bus.step_busy), 32'h1);
        chk("st_halted_lo", 32'(bus.halted), 32'h0);
        nb = 0;
        ne = 0;
        for (int i = 0; i < 7; i++) begin
            bus.stall_req = (i == 1) ? 5'b00010 : 5'b00000;
            #1;
            if (bus.step_busy) nb++;
            if (bus.stage_en != '0) ne++;
            if (i == 1) chk("st_stall_en", 32'(bus.stage_en), 32'h1c);
            tick();
        end
        bus.stall_req = '0;
        chk("st_busy_cycles", 32'(nb), 32'd4);
        chk("st_en_cycles", 32'(ne), 32'd4);
        chk("st_halted", 32'(bus.halted), 32'h1);
        chk("st_valid", 32'(bus.stage_valid), 32'h0f);

        // debug_count=0 runs one advancing cycle; a second edge in STEP is dropped
        bus.debug_step = 1'b0;
        tick();
        bus.debug_count = 8'd0;
        bus.debug_step  = 1'b1;
        tick();
        adv = 0;
        nb  = 0;
        for (int i = 0; i < 5; i++) begin
            bus.debug_step = (i == 0) ? 1'b0 : 1'b1;
            bus.stall_req  = (i == 0) ? 5'b00010 : 5'b00000;
            #1;
            if (bus.stage_en == 5'b11111) adv++;
            if (bus.step_busy) nb++;
            tick();
        end
        bus.stall_req = '0;
        chk("z_adv_cycles", 32'(adv), 32'd1);
        chk("z_busy_cycles", 32'(nb), 32'd2);
        chk("z_halted", 32'(bus.halted), 32'h1);

        // Reset in the middle of a 5-cycle burst
        bus.debug_step = 1'b0;
        tick();
        bus.debug_count = 8'd5;
        bus.debug_step  = 1'b1;
        tick();
        chk("mr_busy", 32'(bus.step_busy), 32'h1);
        rst = 1'b0;
        #1;
        chk("mr_stage_rst", 32'(bus.stage_rst), 32'h1f);
        chk("mr_stage_en", 32'(bus.stage_en), 32'h00);
        chk("mr_valid", 32'(bus.stage_valid), 32'h00);
        chk("mr_busy_lo", 32'(bus.step_busy), 32'h0);
        chk("mr_halted_lo", 32'(bus.halted), 32'h0);
        tick();
        bus.debug_step = 1'b0;
        rst = 1'b1;
        #1;
        chk("mr_rel_en", 32'(bus.stage_en), 32'h1f);
        tick();
        chk("mr_rel_halted", 32'(bus.halted), 32'h1);

        // Leaving debug mode resumes free run
        bus.debug_en = 1'b0;
        tick();
        chk("exit_halted", 32'(bus.halted), 32'h0);
        chk("exit_en", 32'(bus.stage_en), 32'h1f);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
